vram_arbiter: RTL and testbench

//  Schedules the single-port framebuffer RAM behind the VGA timing generator.

---
 rtl/vram_pkg.sv | 18 +
 rtl/rr_arb2.sv | 45 ++++
 rtl/vram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and types for the framebuffer RAM scheduler.
// Framebuffer geometry defaults, scan region encoding and host requester ids.
package vram_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_SCALE    = 1;

   localparam int unsigned FB_W     = DEF_H_ACTIVE >> DEF_SCALE;
   localparam int unsigned FB_H     = DEF_V_ACTIVE >> DEF_SCALE;
   localparam int unsigned FB_WORDS = FB_W * FB_H;

   typedef enum logic [1:0] {VIS, HBL, VBL} region_t;

   // Bit position of each requester in the arbiter request/grant vectors.
   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. The history only moves when a grant is actually issued.
module rr_arb2
   import vram_pkg::*;
(
   input  logic       ckVideo,
   input  logic       rstVideo_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   req_id_t lastQ, lastD;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (lastQ == REQ_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_comb begin
      lastD = lastQ;
      if (gnt[0]) begin
         lastD = REQ_A;
      end else if (gnt[1]) begin
         lastD = REQ_B;
      end
   end

   // Starts as B so that A wins the first tie after reset.
   always_ff @(posedge ckVideo or negedge rstVideo_n) begin
      if (!rstVideo_n) begin
         lastQ <= REQ_B;
      end else begin
         lastQ <= lastD;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM scheduler: display fetch owns fixed pixel slots,
// the CPU (A) and blitter (B) share every other cycle round-robin.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned SCALE    = DEF_SCALE
) (
   input  logic              ckVideo,
   input  logic              rstVideo_n,
   input  logic [9:0]        adrHor,
   input  logic [9:0]        adrVer,
   input  logic              flgActiveVideo,
   input  logic              cfgVblankOnly,
   input  logic              aValid,
   input  logic              aWe,
   input  logic [ADDR_W-1:0] aAddr,
   input  logic [DATA_W-1:0] aWdata,
   output logic              aReady,
   output logic              aRspValid,
   input  logic              bValid,
   input  logic              bWe,
   input  logic [ADDR_W-1:0] bAddr,
   input  logic [DATA_W-1:0] bWdata,
   output logic              bReady,
   output logic              bRspValid,
   output logic [DATA_W-1:0] rspData,
   output logic              errOob,
   output logic [ADDR_W-1:0] ramAddr,
   output logic              ramWe,
   output logic [DATA_W-1:0] ramWdata,
   input  logic [DATA_W-1:0] ramRdata,
   output logic [DATA_W-1:0] pixData,
   output logic              frameStart
);

   localparam int unsigned FbW     = H_ACTIVE >> SCALE;
   localparam int unsigned FbH     = V_ACTIVE >> SCALE;
   localparam int unsigned FbWords = FbW * FbH;
   localparam logic [9:0]  SlotMask = 10'((1 << SCALE) - 1);

   // ---------------------------------------------------------------- region FSM
   region_t regionQ, regionD;
   logic    vBlank;

   assign vBlank = 32'(adrVer) >= V_ACTIVE;

   always_comb begin
      regionD = regionQ;
      unique case (regionQ)
         VIS: begin
            if (!flgActiveVideo) begin
               regionD = vBlank ? VBL : HBL;
            end
         end
         HBL: begin
            if (flgActiveVideo) begin
               regionD = VIS;
            end else if (vBlank) begin
               regionD = VBL;
            end
         end
         VBL: begin
            if (!vBlank) begin
               regionD = flgActiveVideo ? VIS : HBL;
            end
         end
         default: regionD = VIS;
      endcase
   end

   always_ff @(posedge ckVideo or negedge rstVideo_n) begin
      if (!rstVideo_n) begin
         regionQ <= VIS;
      end else begin
         regionQ <= regionD;
      end
   end

   // ---------------------------------------------------------------- slot decode
   logic              dispSlot;
   logic [ADDR_W-1:0] dispAddr;

   // Qualified by reset so that every combinational output reads 0 while held.
   assign dispSlot = rstVideo_n && flgActiveVideo && ((adrHor & SlotMask) == '0);
   assign dispAddr = ADDR_W'(adrVer >> SCALE) * ADDR_W'(FbW) + ADDR_W'(adrHor >> SCALE);

   // ---------------------------------------------------------------- host arbitration
   logic       wrOk;
   logic       aElig, bElig;
   logic [1:0] gnt;

   // Reads are never held off by the vblank-only write policy.
   assign wrOk  = !cfgVblankOnly || (regionD == VBL);
   assign aElig = aValid && (!aWe || wrOk);
   assign bElig = bValid && (!bWe || wrOk);

   rr_arb2 uArb (
      .ckVideo    (ckVideo),
      .rstVideo_n (rstVideo_n),
      .req        ({bElig, aElig}),
      .en         (rstVideo_n && !dispSlot),
      .gnt        (gnt)
   );

   assign aReady = gnt[0];
   assign bReady = gnt[1];

   logic              hostGnt;
   logic              hostWe;
   logic              hostOob;
   req_id_t           hostId;
   logic [ADDR_W-1:0] hostAddr;
   logic [DATA_W-1:0] hostWdata;

   assign hostGnt   = |gnt;
   assign hostId    = gnt[1] ? REQ_B : REQ_A;
   assign hostWe    = gnt[1] ? bWe : aWe;
   assign hostAddr  = gnt[1] ? bAddr : aAddr;
   assign hostWdata = gnt[1] ? bWdata : aWdata;
   assign hostOob   = hostGnt && (32'(hostAddr) >= FbWords);
   assign errOob    = hostOob;

   // ---------------------------------------------------------------- RAM port
   always_comb begin
      ramAddr  = '0;
      ramWe    = 1'b0;
      ramWdata = '0;
      if (dispSlot) begin
         ramAddr = dispAddr;
      end else if (hostGnt) begin
         ramAddr = hostAddr;
         if (hostWe) begin
            ramWe    = !hostOob;
            ramWdata = hostWdata;
         end
      end
   end

   // ---------------------------------------------------------------- return pipelines
   logic              rd1ValidQ, rd1OobQ;
   req_id_t           rd1IdQ, rspIdQ;
   logic              rspValidQ;
   logic [DATA_W-1:0] rspDataQ;
   logic              slot1Q, act1Q, act2Q;
   logic [DATA_W-1:0] pixQ;

   // Stage 1 waits out the RAM latency; stage 2 captures ramRdata.
   always_ff @(posedge ckVideo or negedge rstVideo_n) begin
      if (!rstVideo_n) begin
         rd1ValidQ <= 1'b0;
         rd1OobQ   <= 1'b0;
         rd1IdQ    <= REQ_A;
         rspValidQ <= 1'b0;
         rspIdQ    <= REQ_A;
         rspDataQ  <= '0;
         slot1Q    <= 1'b0;
         act1Q     <= 1'b0;
         act2Q     <= 1'b0;
         pixQ      <= '0;
      end else begin
         rd1ValidQ <= hostGnt && !hostWe;
         rd1OobQ   <= hostOob;
         rd1IdQ    <= hostId;
         rspValidQ <= rd1ValidQ;
         rspIdQ    <= rd1IdQ;
         rspDataQ  <= (rd1ValidQ && !rd1OobQ) ? ramRdata : '0;
         slot1Q    <= dispSlot;
         act1Q     <= flgActiveVideo;
         act2Q     <= act1Q;
         if (slot1Q) begin
            pixQ <= ramRdata;
         end
      end
   end

   assign aRspValid  = rspValidQ && (rspIdQ == REQ_A);
   assign bRspValid  = rspValidQ && (rspIdQ == REQ_B);
   assign rspData    = rspDataQ;
   assign pixData    = act2Q ? pixQ : '0;
   assign frameStart = rstVideo_n && (adrHor == '0) && (adrVer == '0);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, spec-level reference model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_vram_arbiter;

   localparam int FbWords = 76800;

   logic        ckVideo = 1'b0;
   logic        rstVideo_n;
   logic [9:0]  adrHor, adrVer;
   logic        flgActiveVideo, cfgVblankOnly;
   logic        aValid, aWe, bValid, bWe;
   logic [16:0] aAddr, bAddr;
   logic [11:0] aWdata, bWdata;
   logic        aReady, bReady, aRspValid, bRspValid, errOob, ramWe, frameStart;
   logic [11:0] rspData, ramWdata, ramRdata, pixData;
   logic [16:0] ramAddr;

   int compared   = 0;
   int mismatched = 0;

   logic [11:0] mem    [0:131071];
   logic [11:0] shadow [0:FbWords-1];

   always #5 ckVideo = ~ckVideo;

   vram_arbiter dut (
      .ckVideo        (ckVideo),
      .rstVideo_n     (rstVideo_n),
      .adrHor         (adrHor),
      .adrVer         (adrVer),
      .flgActiveVideo (flgActiveVideo),
      .cfgVblankOnly  (cfgVblankOnly),
      .aValid         (aValid),
      .aWe            (aWe),
      .aAddr          (aAddr),
      .aWdata         (aWdata),
      .aReady         (aReady),
      .aRspValid      (aRspValid),
      .bValid         (bValid),
      .bWe            (bWe),
      .bAddr          (bAddr),
      .bWdata         (bWdata),
      .bReady         (bReady),
      .bRspValid      (bRspValid),
      .rspData        (rspData),
      .errOob         (errOob),
      .ramAddr        (ramAddr),
      .ramWe          (ramWe),
      .ramWdata       (ramWdata),
      .ramRdata       (ramRdata),
      .pixData        (pixData),
      .frameStart     (frameStart)
   );

   // Framebuffer RAM, one cycle read latency.
   always @(posedge ckVideo) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      ramRdata <= mem[ramAddr];
   end

   function automatic logic [11:0] initVal(input int a);
      return 12'(a * 7 + 3);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         if (mismatched <= 40) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // ------------------------------------------------------------ reference model
   typedef struct packed {
      logic        rd;
      logic        id;
      logic [11:0] rdData;
      logic        slot;
      logic [11:0] slotData;
      logic        act;
   } hist_t;

   hist_t       h1 = '0, h2 = '0, cur;
   logic [11:0] pixVal = '0;
   bit          lastB = 1'b1;
   bit          mSlot, mWrOk, aE, bE, gA, gB, gWe, oob;
   int          gAddr, dAddr;
   logic [11:0] gData;
   logic        eARdy, eBRdy, eARsp, eBRsp, eWe, eErr, eFrame;
   logic [11:0] eRsp, eWdata, ePix;
   logic [16:0] eRamAddr;

   always @(negedge ckVideo) begin
      cur = '0;
      {eARdy, eBRdy, eARsp, eBRsp, eWe, eErr, eFrame} = '0;
      eRsp = '0; eWdata = '0; ePix = '0; eRamAddr = '0;
      if (!rstVideo_n) begin
         h1 = '0; h2 = '0; pixVal = '0; lastB = 1'b1;
      end else begin
         if (h2.slot) pixVal = h2.slotData;
         ePix  = h2.act ? pixVal : 12'd0;
         eARsp = h2.rd && !h2.id;
         eBRsp = h2.rd && h2.id;
         eRsp  = h2.rd ? h2.rdData : 12'd0;
         mSlot = flgActiveVideo && (adrHor % 2 == 0);
         dAddr = (int'(adrVer) / 2) * 320 + int'(adrHor) / 2;
         mWrOk = !cfgVblankOnly || (adrVer >= 480);
         aE    = aValid && !mSlot && (!aWe || mWrOk);
         bE    = bValid && !mSlot && (!bWe || mWrOk);
         gA    = aE && (!bE || lastB);
         gB    = bE && !gA;
         if (gA) lastB = 1'b0;
         if (gB) lastB = 1'b1;
         eARdy  = gA;
         eBRdy  = gB;
         eFrame = (adrHor == 0) && (adrVer == 0);
         gAddr  = gA ? int'(aAddr) : int'(bAddr);
         gWe    = gA ? aWe : bWe;
         gData  = gA ? aWdata : bWdata;
         if (mSlot) begin
            eRamAddr     = 17'(dAddr);
            cur.slot     = 1'b1;
            cur.slotData = shadow[dAddr];
         end else if (gA || gB) begin
            eRamAddr = 17'(gAddr);
            oob      = gAddr >= FbWords;
            eErr     = oob;
            if (gWe) begin
               eWe    = !oob;
               eWdata = gData;
               if (!oob) shadow[gAddr] = gData;
            end else begin
               cur.rd     = 1'b1;
               cur.id     = gB;
               cur.rdData = oob ? 12'd0 : shadow[gAddr];
            end
         end
         cur.act = flgActiveVideo;
         h2 = h1;
         h1 = cur;
      end
      check("aReady", aReady, eARdy);
      check("bReady", bReady, eBRdy);
      check("aRspValid", aRspValid, eARsp);
      check("bRspValid", bRspValid, eBRsp);
      check("rspData", rspData, eRsp);
      check("ramAddr", ramAddr, eRamAddr);
      check("ramWe", ramWe, eWe);
      check("ramWdata", ramWdata, eWdata);
      check("errOob", errOob, eErr);
      check("pixData", pixData, ePix);
      check("frameStart", frameStart, eFrame);
   end

   // ------------------------------------------------------------ stimulus helpers
   logic        sARdy, sBRdy, sARsp, sBRsp, sWe, sErr, sFrame;
   logic [11:0] sRsp, sPix;
   logic [16:0] sRamAddr;
   logic [9:0]  sH;

   task automatic setPos(input int hh, input int vv);
      adrHor = 10'(hh);
      adrVer = 10'(vv);
      flgActiveVideo = (adrHor < 640) && (adrVer < 480);
   endtask

   // Samples this cycle's outputs, then advances the pixel counter.
   task automatic tick();
      @(negedge ckVideo);
      sARdy = aReady; sBRdy = bReady; sARsp = aRspValid; sBRsp = bRspValid;
      sRsp = rspData; sRamAddr = ramAddr; sWe = ramWe; sErr = errOob;
      sPix = pixData; sFrame = frameStart; sH = adrHor;
      @(posedge ckVideo);
      #1;
      adrHor = (adrHor == 10'd799) ? 10'd0 : adrHor + 10'd1;
      flgActiveVideo = (adrHor < 640) && (adrVer < 480);
   endtask

   task automatic doReq(input bit isA, input bit we, input int addr, input int data);
      bit got = 1'b0;
      if (isA) begin
         aValid = 1'b1; aWe = we; aAddr = 17'(addr); aWdata = 12'(data);
      end else begin
         bValid = 1'b1; bWe = we; bAddr = 17'(addr); bWdata = 12'(data);
      end
      for (int i = 0; i < 64 && !got; i++) begin
         tick();
         got = isA ? sARdy : sBRdy;
      end
      if (isA) aValid = 1'b0;
      else     bValid = 1'b0;
      if (!got) check("reqTimeout", 0, 1);
   endtask

   // ------------------------------------------------------------ directed scenarios
   bit          seq [0:7];
   logic [11:0] rr  [0:7];
   int          n, nr;

   initial begin
      for (int i = 0; i < 131072; i++) mem[i] = initVal(i);
      for (int i = 0; i < FbWords; i++) shadow[i] = initVal(i);
      rstVideo_n = 1'b0; cfgVblankOnly = 1'b0;
      aValid = 1'b1; aWe = 1'b0; aAddr = 17'd5; aWdata = '0;
      bValid = 1'b0; bWe = 1'b0; bAddr = '0; bWdata = '0;
      setPos(5, 7);

      // Reset holds every output low even with a pending request.
      tick(); tick();
      check("rstReady", sARdy, 0);
      check("rstRamAddr", sRamAddr, 0);
      check("rstPix", sPix, 0);
      aValid = 1'b0;
      rstVideo_n = 1'b1;

      // Frame start and display fetch.
      setPos(0, 0);
      tick();
      check("frameStartPulse", sFrame, 1);
      setPos(4, 6);
      tick();
      check("dispAddr962", sRamAddr, 962);
      tick(); tick();
      check("pixLatency", sPix, 12'hA51);
      tick();
      check("pixHold", sPix, 12'hA51);
      tick();
      check("pixNext963", sPix, 12'hA58);

      // Host writes during an active line only land in odd cycles.
      setPos(0, 20);
      doReq(1'b1, 1'b1, 1000, 12'h123);
      check("contFirstH", sH, 1);
      check("contWe", sWe, 1);
      check("contAddr", sRamAddr, 1000);
      doReq(1'b1, 1'b1, 1001, 12'h124);
      check("contOdd1", sH[0], 1);
      doReq(1'b1, 1'b1, 1002, 12'h125);
      check("contOdd2", sH[0], 1);
      setPos(650, 20);
      doReq(1'b1, 1'b0, 1000, 0);
      tick(); tick();
      check("readBackValid", sARsp, 1);
      check("readBackData", sRsp, 12'h123);

      // Mid-frame reset discards an in-flight read.
      setPos(650, 200);
      doReq(1'b1, 1'b0, 5, 0);
      rstVideo_n = 1'b0;
      aValid = 1'b1; aWe = 1'b0; aAddr = 17'd6;
      tick();
      check("midRstReady", sARdy, 0);
      check("midRstRsp", sARsp, 0);
      tick();
      rstVideo_n = 1'b1;
      aValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("postRstNoRsp", sARsp | sBRsp, 0);
      end

      // Round-robin in horizontal blanking; first tie after reset goes to A.
      setPos(660, 30);
      aValid = 1'b1; aWe = 1'b0; aAddr = 17'd10;
      bValid = 1'b1; bWe = 1'b0; bAddr = 17'd20;
      n = 0; nr = 0;
      for (int i = 0; i < 12 && n < 4; i++) begin
         tick();
         if ((sARsp || sBRsp) && nr < 8) begin rr[nr] = sRsp; nr++; end
         if (sARdy && n < 8) begin seq[n] = 1'b0; n++; aAddr = aAddr + 17'd1; end
         if (sBRdy && n < 8) begin seq[n] = 1'b1; n++; bAddr = bAddr + 17'd1; end
      end
      aValid = 1'b0; bValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if ((sARsp || sBRsp) && nr < 8) begin rr[nr] = sRsp; nr++; end
      end
      check("rrGrants", n, 4);
      check("rrSeq", {seq[0], seq[1], seq[2], seq[3]}, 4'b0101);
      check("rrRspCount", nr, 4);
      check("rrRsp0", rr[0], 12'h049);
      check("rrRsp1", rr[1], 12'h08F);
      check("rrRsp2", rr[2], 12'h050);
      check("rrRsp3", rr[3], 12'h096);

      // Vblank-only writes: B write waits, A read proceeds.
      cfgVblankOnly = 1'b1;
      setPos(650, 100);
      bValid = 1'b1; bWe = 1'b1; bAddr = 17'd500; bWdata = 12'hBEE;
      aValid = 1'b1; aWe = 1'b0; aAddr = 17'd7;
      tick();
      check("vbBlocked", sBRdy, 0);
      check("vbReadGo", sARdy, 1);
      aValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("vbHold", sBRdy, 0);
      end
      adrVer = 10'd480;
      flgActiveVideo = 1'b0;
      tick();
      check("vbGrant480", sBRdy, 1);
      bValid = 1'b0;
      cfgVblankOnly = 1'b0;
      setPos(650, 100);
      doReq(1'b1, 1'b0, 500, 0);
      tick(); tick();
      check("vbData", sRsp, 12'hBEE);

      // Out-of-range write and read.
      setPos(650, 300);
      doReq(1'b1, 1'b1, 76800, 12'hFFF);
      check("oobWrErr", sErr, 1);
      check("oobWrWe", sWe, 0);
      doReq(1'b1, 1'b0, 76800, 0);
      check("oobRdErr", sErr, 1);
      tick(); tick();
      check("oobRspValid", sARsp, 1);
      check("oobRspData", sRsp, 0);

      for (int i = 0; i < 4; i++) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
